pp_burst_arbiter: RTL and testbench
===================================

// Module: pp_burst_arbiter
// PURPOSE
//  Round-robin burst arbiter that lets two 64-bit source streams share the single write port of the ping-pong RAM buffer.
//  Grants one source for a whole fixed-length burst (one RAM half, 64 words), so a RAM half never holds words from two sources.
//  Sits directly upstream of the ping-pong controller: m_valid/m_data drive its data_en/data_in, and i_buf_ready is its o_upstream_ready.
// PARAMETERS
//  DATA_W     64   word width of both sources and of the master output
//  BURST_LEN  64   beats per grant; must equal the ping-pong half depth; range 2..256
//  CNT_W      8    beat counter width; must satisfy 2**CNT_W >= BURST_LEN
// PORTS
//  clk_50m        in   1       system clock; all logic is on the rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  i_enable       in   1       0 = issue no new grants; a burst already in progress still completes
//  s0_valid       in   1       source 0 word valid
//  s0_data        in   DATA_W  source 0 word
//  s0_ready       out  1       source 0 word accepted this cycle (only when valid is also high)
//  s1_valid       in   1       source 1 word valid
//  s1_data        in   DATA_W  source 1 word
//  s1_ready       out  1       source 1 word accepted this cycle (only when valid is also high)
//  m_valid        out  1       word to the buffer (drives data_en)
//  m_data         out  DATA_W  word to the buffer (drives data_in)
//  i_buf_ready    in   1       buffer can accept a word (its o_upstream_ready)
//  o_grant        out  2       one-hot grant: bit0 = source 0, bit1 = source 1; 2'b00 when idle
//  o_burst_first  out  1       current transfer is beat 0 of the burst
//  o_burst_last   out  1       current transfer is beat BURST_LEN-1 of the burst
//  o_busy         out  1       a burst is in progress
//  o_burst_cnt0   out  16      completed bursts from source 0 (ARB_STATS_EN)
//  o_burst_cnt1   out  16      completed bursts from source 1 (ARB_STATS_EN)
// BEHAVIOUR
//  - Reset values: state=IDLE; o_grant=0; all outputs 0; beat_cnt=0; rr_last=1, so source 0 wins the first tie.
//  - Transfer (xfer) = m_valid & i_buf_ready.
//  - State ARB (IDLE): o_busy=0, ready outputs=0, m_valid=0.
//    * Grant is evaluated only when i_enable=1.
//    * If exactly one source is valid, grant it.
//    * If both are valid, grant the source other than rr_last.
//    * The grant is registered: go to BURST next cycle. A source sees ready no earlier than 1 cycle after it raises valid.
//  - State BURST, granted source g:
//    * m_valid = sg_valid; m_data = sg_data; sg_ready = i_buf_ready.
//    * These three are combinational pass-through with zero latency. The non-granted source's ready is 0.
//    * beat_cnt increments on each xfer.
//    * o_burst_first = xfer & (beat_cnt==0); o_burst_last = xfer & (beat_cnt==BURST_LEN-1).
//    * On the last-beat xfer: beat_cnt -> 0, rr_last <= g, next state ARB. This gives one bubble cycle between bursts.
//    * Stalls on either side (valid low or ready low) hold beat_cnt. No timeout; the grant is held indefinitely.
//  - i_enable falling mid-burst does not cut the burst; the burst runs to BURST_LEN beats.
//  - A source's valid dropping mid-burst only stalls the burst; the grant is kept.
//  - m_data is don't-care while m_valid=0 and is driven 0 in ARB.
//  - Async reset mid-burst: returns to ARB at once. The partial burst is abandoned; the downstream buffer is reset by the same rst_n.
//  - beat_cnt width rule: compare against BURST_LEN-1 truncated to CNT_W. Never wraps past BURST_LEN-1.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    * o_burst_cnt0 / o_burst_cnt1 are 16-bit counters, reset to 0.
//    * +1 on each last-beat xfer of the matching source; saturate at 16'hFFFF.
//  ARB_STATS_EN undefined:
//    * Both ports are still present and are tied to 16'd0.
//    * No counter flops are synthesised.
// TESTING
//  1 Only s0 streams 128 words, buf_ready=1:
//    * o_grant=01 for two bursts, 1 bubble cycle between them.
//    * o_burst_first on words 0 and 64; o_burst_last on words 63 and 127.
//  2 s0 and s1 both valid from reset, 256 words each:
//    * Grant order s0,s1,s0,s1.
//    * Each burst is exactly 64 words, in order, with no source mixing.
//  3 Mid-burst (beat 20), drop buf_ready for 10 cycles:
//    * m_valid is held, s0_ready=0, beat_cnt stays 20.
//    * Burst resumes and still ends at 64 beats.
//  4 Deassert i_enable at beat 30 with s1 waiting:
//    * The s0 burst completes; then o_grant=00 and s1_ready=0 until i_enable=1.
//    * After i_enable=1, s1 is granted the next cycle.
//  5 Assert rst_n=0 at beat 40:
//    * All outputs are 0 immediately.
//    * After release, s0 wins the tie with s1.
//  6 With ARB_STATS_EN, run 3 s0 bursts and 2 s1 bursts:
//    * o_burst_cnt0=3, o_burst_cnt1=2.
//    * Without the macro, both read 0.

Source files
------------

// File: rtl/pp_burst_arbiter.sv
// Round-robin burst arbiter feeding the ping-pong RAM write port: one source owns a whole BURST_LEN-beat half.
// Optional macro ARB_STATS_EN enables per-source completed-burst counters (ports tie to 0 otherwise).
module pp_burst_arbiter #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              i_buf_ready,
  output logic [1:0]        o_grant,
  output logic              o_burst_first,
  output logic              o_burst_last,
  output logic              o_busy,
  output logic [15:0]       o_burst_cnt0,
  output logic [15:0]       o_burst_cnt1
);

  typedef enum logic {ARB, BURST} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t           r_state, w_stateNext;
  logic [1:0]       r_grant, w_grantNext;
  logic [CNT_W-1:0] r_beatCnt, w_beatCntNext;
  logic             r_rrLast, w_rrLastNext;
  logic             w_xfer, w_lastBeat, w_pick0, w_pick1;

  // r_rrLast holds the source that finished the previous burst; ties go to the other one
  assign w_pick0 = s0_valid & (~s1_valid | r_rrLast);
  assign w_pick1 = s1_valid & (~s0_valid | ~r_rrLast);

  assign m_valid       = (r_grant[0] & s0_valid) | (r_grant[1] & s1_valid);
  assign m_data        = r_grant[0] ? s0_data : (r_grant[1] ? s1_data : '0);
  assign s0_ready      = r_grant[0] & i_buf_ready;
  assign s1_ready      = r_grant[1] & i_buf_ready;
  assign w_xfer        = m_valid & i_buf_ready;
  assign w_lastBeat    = (r_beatCnt == LAST_CNT);
  assign o_burst_first = w_xfer & (r_beatCnt == '0);
  assign o_burst_last  = w_xfer & w_lastBeat;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state == BURST);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_grant   <= 2'b00;
      r_beatCnt <= '0;
      r_rrLast  <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_beatCnt <= w_beatCntNext;
      r_rrLast  <= w_rrLastNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_beatCntNext = r_beatCnt;
    w_rrLastNext  = r_rrLast;
    case (r_state)
      ARB: begin
        if (i_enable && (s0_valid || s1_valid)) begin
          w_grantNext = {w_pick1, w_pick0};
          w_stateNext = BURST;
        end
      end
      BURST: begin
        if (w_xfer) begin
          if (w_lastBeat) begin
            w_beatCntNext = '0;
            w_rrLastNext  = r_grant[1];
            w_grantNext   = 2'b00;
            w_stateNext   = ARB;
          end else begin
            w_beatCntNext = r_beatCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = ARB;
        w_grantNext = 2'b00;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_burstCnt0, r_burstCnt1;

  // Counters saturate rather than wrap so a long run never reads as a small count
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_burstCnt0 <= 16'd0;
      r_burstCnt1 <= 16'd0;
    end else if (o_burst_last) begin
      if (r_grant[0] && (r_burstCnt0 != 16'hFFFF)) r_burstCnt0 <= r_burstCnt0 + 16'd1;
      if (r_grant[1] && (r_burstCnt1 != 16'hFFFF)) r_burstCnt1 <= r_burstCnt1 + 16'd1;
    end
  end

  assign o_burst_cnt0 = r_burstCnt0;
  assign o_burst_cnt1 = r_burstCnt1;
`else
  assign o_burst_cnt0 = 16'd0;
  assign o_burst_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_pp_burst_arbiter.sv
// Directed self-checking bench for pp_burst_arbiter: single/dual-source bursts, stalls, enable gating, reset, stats.
module tb_pp_burst_arbiter;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic        s0_valid, s1_valid;
  logic [63:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic        i_buf_ready;
  logic [1:0]  o_grant;
  logic        o_burst_first, o_burst_last, o_busy;
  logic [15:0] o_burst_cnt0, o_burst_cnt1;

  int checks = 0;
  int errors = 0;
  int s0Word = 0;
  int s1Word = 0;

  pp_burst_arbiter dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .i_enable(i_enable),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .i_buf_ready(i_buf_ready),
    .o_grant(o_grant), .o_burst_first(o_burst_first), .o_burst_last(o_burst_last),
    .o_busy(o_busy), .o_burst_cnt0(o_burst_cnt0), .o_burst_cnt1(o_burst_cnt1)
  );

  // 50 MHz clock
  always #10 clk_50m = ~clk_50m;

  // Every comparison funnels through here so the counters stay in one place
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic en, input logic bufRdy);
    s0_valid    = v0;
    s1_valid    = v1;
    i_enable    = en;
    i_buf_ready = bufRdy;
    s0_data     = 64'hA000_0000_0000_0000 + 64'(s0Word);
    s1_data     = 64'hB000_0000_0000_0000 + 64'(s1Word);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, 64'(o_grant), 64'd0);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_mvalid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_mdata"}, m_data, 64'd0);
    checkOutput({tag, "_s0rdy"}, 64'(s0_ready), 64'd0);
    checkOutput({tag, "_s1rdy"}, 64'(s1_ready), 64'd0);
    checkOutput({tag, "_first"}, 64'(o_burst_first), 64'd0);
    checkOutput({tag, "_last"}, 64'(o_burst_last), 64'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    checkOutput("reset_cnt0", 64'(o_burst_cnt0), 64'd0);
    checkOutput("reset_cnt1", 64'(o_burst_cnt1), 64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Beats first..last of a burst from src, all with buf_ready high and the source valid
  task automatic doBeats(input int src, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      s0_data = 64'hA000_0000_0000_0000 + 64'(s0Word);
      s1_data = 64'hB000_0000_0000_0000 + 64'(s1Word);
      #1;
      checkOutput("beat_grant", 64'(o_grant), (src == 0) ? 64'd1 : 64'd2);
      checkOutput("beat_busy", 64'(o_busy), 64'd1);
      checkOutput("beat_mvalid", 64'(m_valid), 64'd1);
      checkOutput("beat_mdata", m_data,
                  (src == 0) ? 64'hA000_0000_0000_0000 + 64'(s0Word) : 64'hB000_0000_0000_0000 + 64'(s1Word));
      checkOutput("beat_s0rdy", 64'(s0_ready), (src == 0) ? 64'd1 : 64'd0);
      checkOutput("beat_s1rdy", 64'(s1_ready), (src == 1) ? 64'd1 : 64'd0);
      checkOutput("beat_first", 64'(o_burst_first), (k == 0) ? 64'd1 : 64'd0);
      checkOutput("beat_last", 64'(o_burst_last), (k == 63) ? 64'd1 : 64'd0);
      if (src == 0) s0Word++;
      else s1Word++;
      tick();
    end
  endtask

  task automatic checkBubble(input string tag);
    #1;
    checkAllZero(tag);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    doReset();

    $display("[TB] single source, two bursts");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkBubble("t1_arb");
    doBeats(0, 0, 63);
    checkBubble("t1_bubble");
    doBeats(0, 0, 63);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkBubble("t1_end");

    $display("[TB] two sources alternating");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkBubble("t2_arb");
    doBeats(0, 0, 63);
    checkBubble("t2_b1");
    doBeats(1, 0, 63);
    checkBubble("t2_b2");
    doBeats(0, 0, 63);
    checkBubble("t2_b3");
    doBeats(1, 0, 63);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkBubble("t2_end");

    $display("[TB] buffer stall at beat 20");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkBubble("t3_arb");
    doBeats(0, 0, 19);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("stall_mvalid", 64'(m_valid), 64'd1);
      checkOutput("stall_s0rdy", 64'(s0_ready), 64'd0);
      checkOutput("stall_grant", 64'(o_grant), 64'd1);
      checkOutput("stall_mdata", m_data, 64'hA000_0000_0000_0000 + 64'(s0Word));
      checkOutput("stall_first", 64'(o_burst_first), 64'd0);
      checkOutput("stall_last", 64'(o_burst_last), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    doBeats(0, 20, 63);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkBubble("t3_end");

    $display("[TB] enable dropped mid-burst with s1 waiting");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkBubble("t4_arb");
    doBeats(0, 0, 29);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    doBeats(0, 30, 63);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) checkBubble("t4_hold");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkBubble("t4_en");
    doBeats(1, 0, 63);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkBubble("t4_end");

    $display("[TB] reset at beat 40, then stats run");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkBubble("t5_arb");
    doBeats(0, 0, 39);
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkBubble("t5_arb2");
    doBeats(0, 0, 63);
    checkBubble("t6_b1");
    doBeats(1, 0, 63);
    checkBubble("t6_b2");
    doBeats(0, 0, 63);
    checkBubble("t6_b3");
    doBeats(1, 0, 63);
    checkBubble("t6_b4");
    doBeats(0, 0, 63);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
`ifdef ARB_STATS_EN
    checkOutput("stats_cnt0", 64'(o_burst_cnt0), 64'd3);
    checkOutput("stats_cnt1", 64'(o_burst_cnt1), 64'd2);
`else
    checkOutput("stats_cnt0", 64'(o_burst_cnt0), 64'd0);
    checkOutput("stats_cnt1", 64'(o_burst_cnt1), 64'd0);
`endif
    checkAllZero("t6_end");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
